fetch_irq_nested: RTL and testbench
===================================

// Module: fetch_irq_nested
// PURPOSE
//  Parametrised instruction-fetch stage: owns the PC, drives the instruction-memory address, returns the fetched word and PC+1 to decode.
//  Successor to the single-interrupt fetch: NUM_IRQ prioritised interrupt channels, per-channel vectors, and a STACK_DEPTH return-PC stack for nested interrupts.
//  Sits between the instruction memory (combinational read) and the decode pipeline register.
// PARAMETERS
//  PC_W        16      PC / address width
//  NUM_IRQ     4       interrupt channels; index 0 = highest priority
//  STACK_DEPTH 4       max nesting depth (saved-PC entries)
//  VEC_BASE    'h0005  vector of channel 0
//  VEC_STRIDE  'h0004  vector spacing; vector(n) = VEC_BASE + n*VEC_STRIDE, truncated to PC_W
// PORTS
//  clk         in   1         clock, all state on rising edge
//  rst         in   1         synchronous active-high reset
//  new_pc      in   PC_W      branch/jump target from execute
//  jorb        in   1         jump-or-branch resolved, take new_pc
//  ld_stall    in   1         load-use stall, hold PC
//  irq_req     in   NUM_IRQ   level interrupt requests
//  imem_addr   out  PC_W      = pc
//  imem_data   in   16        instruction word at imem_addr (same cycle)
//  instr       out  16        imem_data, forwarded
//  instr_valid out  1         0 = decode must squash instr this cycle
//  pc          out  PC_W      current PC
//  pc_plus1    out  PC_W      pc + 1, wraps modulo 2^PC_W
//  int_ack     out  NUM_IRQ   one-hot, 1-cycle pulse the cycle after a channel is taken
//  int_level   out  clog2(STACK_DEPTH+1)  current nesting depth
//  int_active  out  1         int_level != 0
//  err_flags   out  2         sticky {underflow, overflow_deferred}
// BEHAVIOUR
//  Reset: pc=0, stack empty, int_level=0, active_ch=none, jump_wait=0, int_ack=0, err_flags=0. rst mid-interrupt discards stack.
//  Decode of imem_data[15:12]: 0000 HALT, 0100 JMPWAIT (branch in flight), 0011 RTI; others sequential.
//  Next-PC priority (highest first):
//   1 irq_take  -> vector(ch); push pc; active_ch <= ch; instr_valid=0
//   2 RTI & stack non-empty -> pop; pc <= popped; active_ch <= popped channel
//   3 jorb      -> new_pc; jump_wait <= 0
//   4 hold (HALT | JMPWAIT | jump_wait) -> pc
//   5 ld_stall  -> pc
//   6 else      -> pc_plus1
//  irq_take: ch = lowest set index of irq_req; taken only if (int_level==0 or ch < active_ch) and stack not full and not jorb and not jump_wait and not (RTI this cycle).
//  Deferred request stays pending (level input); if blocked only by full stack, set err_flags[0].
//  Saved PC is pc itself (instruction squashed, re-fetched on return). Stack entry = {ch, pc}.
//  jump_wait sets when JMPWAIT fetched and no jorb and no irq_take; clears on jorb or rst.
//  RTI with empty stack: treated as sequential (pc+1), set err_flags[1].
//  HALT holds until an irq is taken or rst; RTI out of a HALT-entered handler returns to the HALT word.
//  instr_valid=0 also in any hold/stall cycle; otherwise 1. int_level updates same edge as PC.
//  All outputs registered except instr, instr_valid, pc_plus1, imem_addr (combinational from pc/imem_data).
// TESTING
//  Reset then free-run NOPs -> pc 0,1,2,...; at PC_W=4 pc wraps 15->0.
//  irq_req=4'b0100 at pc=8 -> next pc=VEC_BASE+8='h0D, int_ack=4'b0100 one cycle later, int_level=1; RTI -> pc=8, int_level=0.
//  In ch2 handler raise irq_req[0] -> preempt to 'h05, level=2; raise irq_req[3] in ch2 -> ignored until both RTIs.
//  STACK_DEPTH=2, nest 2 then raise higher channel -> not taken, err_flags[0]=1; RTI with empty stack -> err_flags[1]=1, pc+1.
//  JMPWAIT fetched with irq pending -> PC holds, no irq until jorb with new_pc='h20; next cycle irq taken, saved pc='h20.
//  rst asserted at int_level=2 -> next edge pc=0, int_level=0, int_ack=0, err_flags=0.

Source files
------------

// File: rtl/fetch_irq_nested.sv
// Instruction-fetch stage with prioritised, nested interrupt channels.
// Owns the PC, a return-PC stack of {channel, pc} entries, and the halt/jump-wait hold logic.
module fetch_irq_nested #(
    parameter int              PC_W        = 16,
    parameter int              NUM_IRQ     = 4,
    parameter int              STACK_DEPTH = 4,
    parameter logic [PC_W-1:0] VEC_BASE    = 'h0005,
    parameter logic [PC_W-1:0] VEC_STRIDE  = 'h0004,
    localparam int             LVL_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    new_pc,
    input  logic               jorb,
    input  logic               ld_stall,
    input  logic [NUM_IRQ-1:0] irq_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [15:0]        imem_data,
    output logic [15:0]        instr,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_plus1,
    output logic [NUM_IRQ-1:0] int_ack,
    output logic [LVL_W-1:0]   int_level,
    output logic               int_active,
    output logic [1:0]         err_flags
);
    localparam int CH_W  = $clog2(NUM_IRQ + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int ENT_W = CH_W + PC_W;
    localparam logic [CH_W-1:0] CH_NONE    = CH_W'(NUM_IRQ);
    localparam logic [3:0]      OP_HALT    = 4'b0000;
    localparam logic [3:0]      OP_JMPWAIT = 4'b0100;
    localparam logic [3:0]      OP_RTI     = 4'b0011;

    logic [CH_W-1:0]    active_ch, active_ch_next, req_ch;
    logic               req_any;
    logic               jump_wait, jump_wait_next;
    logic [PC_W-1:0]    pc_next;
    logic [LVL_W-1:0]   level_next;
    logic [NUM_IRQ-1:0] ack_next;
    logic [1:0]         err_set;
    logic [ENT_W-1:0]   stack_mem [STACK_DEPTH];
    logic [ENT_W-1:0]   top_entry;
    logic [IDX_W-1:0]   push_idx, pop_idx;
    logic               stack_full, stack_empty;
    logic               is_rti, is_jmpwait, is_hold_op;
    logic               irq_ok, irq_take, do_pop;

    assign imem_addr = pc;
    assign instr     = imem_data;
    assign pc_plus1  = pc + PC_W'(1);

    assign stack_full  = (int_level == LVL_W'(STACK_DEPTH));
    assign stack_empty = (int_level == '0);
    assign push_idx    = IDX_W'(int_level);
    assign pop_idx     = IDX_W'(int_level - LVL_W'(1));
    assign top_entry   = stack_mem[pop_idx];

    assign is_rti     = (imem_data[15:12] == OP_RTI);
    assign is_jmpwait = (imem_data[15:12] == OP_JMPWAIT);
    assign is_hold_op = (imem_data[15:12] == OP_HALT) || is_jmpwait;

    // Lowest set index wins: scan from the top so the last hit is the smallest.
    always_comb begin
        req_any = 1'b0;
        req_ch  = CH_NONE;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_req[i]) begin
                req_any = 1'b1;
                req_ch  = CH_W'(i);
            end
        end
    end

    // irq_ok ignores stack space so a request blocked only by a full stack can be flagged.
    assign irq_ok   = req_any && (stack_empty || (req_ch < active_ch))
                      && !jorb && !jump_wait && !is_rti;
    assign irq_take = irq_ok && !stack_full;
    assign do_pop   = is_rti && !stack_empty;

    always_comb begin
        pc_next        = pc;
        level_next     = int_level;
        active_ch_next = active_ch;
        ack_next       = '0;
        err_set        = '0;
        instr_valid    = 1'b1;
        jump_wait_next = jorb ? 1'b0 : (jump_wait || (is_jmpwait && !irq_take));
        err_set[0]     = irq_ok && stack_full;

        if (irq_take) begin
            pc_next        = VEC_BASE + PC_W'(req_ch) * VEC_STRIDE;
            level_next     = int_level + LVL_W'(1);
            active_ch_next = req_ch;
            ack_next       = NUM_IRQ'(1) << req_ch;
            instr_valid    = 1'b0;
        end else if (do_pop) begin
            pc_next        = top_entry[PC_W-1:0];
            active_ch_next = top_entry[ENT_W-1:PC_W];
            level_next     = int_level - LVL_W'(1);
        end else begin
            err_set[1] = is_rti;
            if (jorb) begin
                pc_next = new_pc;
            end else if (is_hold_op || jump_wait || ld_stall) begin
                instr_valid = 1'b0;
            end else begin
                pc_next = pc_plus1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= '0;
            int_level  <= '0;
            int_active <= 1'b0;
            active_ch  <= CH_NONE;
            jump_wait  <= 1'b0;
            int_ack    <= '0;
            err_flags  <= '0;
        end else begin
            pc         <= pc_next;
            int_level  <= level_next;
            int_active <= (level_next != '0);
            active_ch  <= active_ch_next;
            jump_wait  <= jump_wait_next;
            int_ack    <= ack_next;
            err_flags  <= err_flags | err_set;
        end
    end

    // Saved PC is the squashed instruction's own address, so it is re-fetched on return.
    always_ff @(posedge clk) begin
        if (!rst && irq_take) begin
            stack_mem[push_idx] <= {active_ch, pc};
        end
    end

endmodule

// File: tb/tb_fetch_irq_nested.sv
// Randomised and directed bench for fetch_irq_nested against a queue-based reference model.
module tb_fetch_irq_nested;
    localparam int NIRQ    = 4;
    localparam int DEPTH   = 2;
    localparam int VBASE   = 5;
    localparam int VSTRIDE = 4;

    localparam logic [15:0] W_NOP  = 16'h1000;
    localparam logic [15:0] W_HALT = 16'h0000;
    localparam logic [15:0] W_JW   = 16'h4000;
    localparam logic [15:0] W_RTI  = 16'h3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] new_pc = '0;
    logic        jorb = 1'b0;
    logic        ld_stall = 1'b0;
    logic [3:0]  irq_req = '0;
    logic [15:0] imem_addr, imem_data, instr, pc, pc_plus1;
    logic        instr_valid, int_active;
    logic [3:0]  int_ack;
    logic [1:0]  int_level, err_flags;

    logic [15:0] mem [64];
    assign imem_data = mem[imem_addr[5:0]];

    fetch_irq_nested #(.PC_W(16), .NUM_IRQ(NIRQ), .STACK_DEPTH(DEPTH),
                       .VEC_BASE(16'h0005), .VEC_STRIDE(16'h0004)) dut (
        .clk(clk), .rst(rst), .new_pc(new_pc), .jorb(jorb), .ld_stall(ld_stall),
        .irq_req(irq_req), .imem_addr(imem_addr), .imem_data(imem_data),
        .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus1(pc_plus1),
        .int_ack(int_ack), .int_level(int_level), .int_active(int_active),
        .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; logic [15:0] pc; } ent_t;
    ent_t        stk[$];
    logic [15:0] m_pc = '0;
    int          m_act = NIRQ;
    bit          m_jw = 1'b0;
    logic [1:0]  m_err = '0;
    logic [3:0]  m_ack = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit j, input logic [15:0] np, input bit st,
                         input logic [3:0] irq);
        logic [15:0] w, nxt_pc;
        logic [3:0]  op;
        int          ch;
        bit          full, empty, is_rti, elig, take, nxt_jw, exp_valid;
        ent_t        e;
        @(negedge clk);
        rst = r; jorb = j; new_pc = np; ld_stall = st; irq_req = irq;
        #1;
        w = mem[m_pc[5:0]];
        if (r) begin
            m_pc = '0; stk.delete(); m_act = NIRQ; m_jw = 1'b0; m_err = '0; m_ack = '0;
        end else begin
            nxt_pc = m_pc + 16'd1;
            check_val("imem_addr", imem_addr, m_pc);
            check_val("instr", instr, w);
            check_val("pc_plus1", pc_plus1, nxt_pc);
            op = w[15:12];
            is_rti = (op == 4'h3);
            full  = (stk.size() == DEPTH);
            empty = (stk.size() == 0);
            ch = -1;
            for (int i = NIRQ - 1; i >= 0; i--) if (irq[i]) ch = i;
            elig = (ch >= 0) && (empty || ch < m_act) && !j && !m_jw && !is_rti;
            take = elig && !full;
            if (elig && full) m_err[0] = 1'b1;
            nxt_jw = j ? 1'b0 : (m_jw || (op == 4'h4 && !take));
            m_ack = '0;
            if (take) begin
                stk.push_back('{m_act, m_pc});
                m_act = ch;
                m_ack[ch] = 1'b1;
                m_pc = 16'(VBASE + ch * VSTRIDE);
                exp_valid = 1'b0;
            end else if (is_rti && !empty) begin
                e = stk.pop_back();
                m_pc = e.pc;
                m_act = e.ch;
                exp_valid = 1'b1;
            end else begin
                if (is_rti) m_err[1] = 1'b1;
                if (j) begin
                    m_pc = np;
                    exp_valid = 1'b1;
                end else if (op == 4'h0 || op == 4'h4 || m_jw || st) begin
                    exp_valid = 1'b0;
                end else begin
                    m_pc = nxt_pc;
                    exp_valid = 1'b1;
                end
            end
            m_jw = nxt_jw;
            check_val("instr_valid", instr_valid, exp_valid);
        end
        @(posedge clk);
        #1;
        check_val("pc", pc, m_pc);
        check_val("int_level", int_level, stk.size());
        check_val("int_active", int_active, stk.size() != 0);
        check_val("int_ack", int_ack, m_ack);
        check_val("err_flags", err_flags, m_err);
    endtask

    task automatic idle(input logic [3:0] irq);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, irq);
    endtask

    task automatic jump(input logic [15:0] np, input logic [3:0] irq);
        cycle(1'b0, 1'b1, np, 1'b0, irq);
    endtask

    task automatic run_until(input string tag, input logic [15:0] tgt, input logic [3:0] irq,
                             input int max);
        int n = 0;
        while (m_pc != tgt && n < max) begin
            idle(irq);
            n++;
        end
        check_val(tag, pc, tgt);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = W_NOP;
        mem[6'h06] = W_RTI;   // ch0 handler 05..06
        mem[6'h10] = W_RTI;   // ch1/ch2 handlers end here
        mem[6'h13] = W_RTI;   // ch3 handler 11..13
        mem[6'h18] = W_JW;
        mem[6'h28] = W_HALT;

        cycle(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
        check_val("rst_pc", pc, 16'h0000);
        check_val("rst_level", int_level, 2'd0);
        check_val("rst_ack", int_ack, 4'h0);
        check_val("rst_err", err_flags, 2'b00);

        // Sequential run, then channel 2 at pc=8
        run_until("seq_to_8", 16'h0008, 4'h0, 20);
        idle(4'b0100);
        check_val("ch2_vec", pc, 16'h000D);
        check_val("ch2_ack", int_ack, 4'b0100);
        check_val("ch2_lvl", int_level, 2'd1);
        idle(4'b0101);
        check_val("ch0_preempt", pc, 16'h0005);
        check_val("ch0_lvl", int_level, 2'd2);
        idle(4'b1100);
        idle(4'b1100);
        check_val("rti_to_ch2", pc, 16'h000D);
        run_until("rti_to_8", 16'h0008, 4'b1000, 20);
        check_val("rti_lvl0", int_level, 2'd0);
        idle(4'b1000);
        check_val("ch3_vec", pc, 16'h0011);
        check_val("ch3_ack", int_ack, 4'b1000);

        // Full stack blocks a higher channel
        idle(4'b1100);
        check_val("nest2_pc", pc, 16'h000D);
        idle(4'b1101);
        check_val("ovf_flag", err_flags[0], 1'b1);
        check_val("ovf_pc", pc, 16'h000E);
        run_until("unwind", 16'h0008, 4'h0, 30);

        // RTI with empty stack
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
        run_until("undf_pc", 16'h0007, 4'h0, 20);
        check_val("undf_flag", err_flags, 2'b10);

        // PC wrap
        jump(16'hFFFE, 4'h0);
        idle(4'h0);
        idle(4'h0);
        check_val("wrap_pc", pc, 16'h0000);

        // JMPWAIT holds and blocks interrupts until jorb
        jump(16'h0018, 4'h0);
        idle(4'h0);
        for (int i = 0; i < 3; i++) idle(4'b0010);
        check_val("jw_hold", pc, 16'h0018);
        jump(16'h0020, 4'b0010);
        check_val("jw_jump", pc, 16'h0020);
        idle(4'b0010);
        check_val("jw_irq", pc, 16'h0009);
        run_until("jw_ret", 16'h0020, 4'h0, 20);
        check_val("jw_ret_lvl", int_level, 2'd0);

        // HALT held until interrupt, RTI returns to the HALT word
        jump(16'h0028, 4'h0);
        for (int i = 0; i < 3; i++) idle(4'h0);
        check_val("halt_hold", pc, 16'h0028);
        idle(4'b0001);
        check_val("halt_irq", pc, 16'h0005);
        idle(4'h0);
        idle(4'h0);
        check_val("halt_ret", pc, 16'h0028);

        // Reset at nesting depth 2
        jump(16'h0020, 4'h0);
        idle(4'b1000);
        idle(4'b0100);
        check_val("deep_lvl", int_level, 2'd2);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 4'b0100);
        check_val("mid_rst_pc", pc, 16'h0000);
        check_val("mid_rst_lvl", int_level, 2'd0);
        check_val("mid_rst_ack", int_ack, 4'h0);
        check_val("mid_rst_err", err_flags, 2'b00);

        // Random program and stimulus
        for (int i = 0; i < 64; i++) begin
            int r;
            logic [15:0] lo;
            r  = $urandom_range(0, 99);
            lo = 16'($urandom_range(0, 4095));
            if (r < 4)       mem[i] = W_HALT | lo;
            else if (r < 9)  mem[i] = W_JW | lo;
            else if (r < 17) mem[i] = W_RTI | lo;
            else             mem[i] = 16'($urandom_range(5, 15) << 12) | lo;
        end
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] irq;
            for (int b = 0; b < 4; b++) irq[b] = ($urandom_range(0, 99) < 18);
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) < 8,
                  16'($urandom),
                  $urandom_range(0, 99) < 15,
                  irq);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
